// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response signal bundle for alu_cmd_sequencer
interface alu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_use_acc;

    logic [7:0]  intop1;
    logic [7:0]  intop2;
    logic [1:0]  opcode;
    logic [7:0]  alu_result;
    logic [15:0] alu_product;
    logic        alu_carry;
    logic        alu_overflow;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic [7:0]  ovf_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output intop1, intop2, opcode,
        input  alu_result, alu_product, alu_carry, alu_overflow,
        output rsp_valid, rsp_data, rsp_op, rsp_carry, rsp_overflow, ovf_count,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  intop1, intop2, opcode,
        output alu_result, alu_product, alu_carry, alu_overflow,
        input  rsp_valid, rsp_data, rsp_op, rsp_carry, rsp_overflow, ovf_count,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/response sequencer in front of the 8-bit ALU
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       use_acc;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_intop1;
    logic [7:0]    r_intop2;
    logic [1:0]    r_opcode;
    logic [7:0]    r_acc;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_data;
    logic [1:0]    r_rsp_op;
    logic          r_rsp_carry;
    logic          r_rsp_overflow;
    logic [7:0]    r_ovf_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_capture;
    logic          w_rsp_done;
    cmd_t          w_cmd_in;
    cmd_t          w_head;
    logic [15:0]   w_rsp_data;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.cmd_valid && !w_full;
    assign w_cmd_in   = '{use_acc: bus.cmd_use_acc, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_rsp_data = (r_opcode == 2'b11) ? bus.alu_product : {8'h00, bus.alu_result};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_rsp_done = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // acc is written at the capture edge, so a chained pop in RESP already sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_intop1       <= '0;
            r_intop2       <= '0;
            r_opcode       <= '0;
            r_acc          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_op       <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_ovf_count    <= '0;
        end else begin
            if (w_pop) begin
                r_intop1 <= w_head.use_acc ? r_acc : w_head.a;
                r_intop2 <= w_head.b;
                r_opcode <= w_head.op;
            end
            if (w_capture) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= w_rsp_data;
                r_rsp_op       <= r_opcode;
                r_rsp_carry    <= bus.alu_carry;
                r_rsp_overflow <= bus.alu_overflow;
                r_acc          <= w_rsp_data[7:0];
                if (bus.alu_overflow && (r_ovf_count != 8'hFF)) begin
                    r_ovf_count <= r_ovf_count + 8'd1;
                end
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready    = !w_full;
    assign bus.intop1       = r_intop1;
    assign bus.intop2       = r_intop2;
    assign bus.opcode       = r_opcode;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_op       = r_rsp_op;
    assign bus.rsp_carry    = r_rsp_carry;
    assign bus.rsp_overflow = r_rsp_overflow;
    assign bus.ovf_count    = r_ovf_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a stand-in ALU
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_ovf = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        v;
        logic        c;
        logic [15:0] p;
        logic [7:0]  r;
    } alu_out_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  op;
        logic        c;
        logic        v;
        logic [7:0]  cnt;
    } exp_t;

    // Stand-in ALU: signed add overflow zeroes the result; product is always a*b.
    function automatic alu_out_t alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_out_t   o;
        logic [8:0] s;
        s   = {1'b0, a} + {1'b0, b};
        o.p = 16'(a) * 16'(b);
        o.c = 1'b0;
        o.v = 1'b0;
        case (op)
            2'b00: begin
                o.c = s[8];
                o.v = (a[7] == b[7]) && (s[7] != a[7]);
                o.r = o.v ? 8'h00 : s[7:0];
            end
            2'b01:   o.r = a & b;
            2'b10:   o.r = a ^ b;
            default: o.r = o.p[7:0];
        endcase
        return o;
    endfunction

    alu_out_t w_alu;
    assign w_alu            = alu_fn(bus.opcode, bus.intop1, bus.intop2);
    assign bus.alu_result   = w_alu.r;
    assign bus.alu_product  = w_alu.p;
    assign bus.alu_carry    = w_alu.c;
    assign bus.alu_overflow = w_alu.v | force_ovf;

    exp_t       exp_q[$];
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_cnt = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        alu_out_t o;
        exp_t     e;
        o      = alu_fn(op, ua ? m_acc : a, b);
        e.data = (op == 2'b11) ? o.p : {8'h00, o.r};
        e.op   = op;
        e.c    = o.c;
        e.v    = o.v | force_ovf;
        if (e.v && m_cnt != 8'hFF) m_cnt++;
        e.cnt  = m_cnt;
        m_acc  = e.data[7:0];
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        int t;
        t = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_use_acc = ua;
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            check("push_timeout", 32'(bus.cmd_ready), 32'd1);
        end else begin
            @(posedge clk);
            model_push(op, a, b, ua);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output int hs_cyc, output logic [15:0] d);
        int   t;
        exp_t e;
        t      = 0;
        hs_cyc = -1;
        d      = 16'hxxxx;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
            e = exp_q.pop_front();
            d = bus.rsp_data;
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("rsp_op", 32'(bus.rsp_op), 32'(e.op));
            check("rsp_carry", 32'(bus.rsp_carry), 32'(e.c));
            check("rsp_overflow", 32'(bus.rsp_overflow), 32'(e.v));
            check("ovf_count", 32'(bus.ovf_count), 32'(e.cnt));
            @(posedge clk);
            @(negedge clk);
            hs_cyc = cyc;
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int          hs;
        int          prev_hs;
        logic [15:0] d;
        logic [15:0] held;
        logic        seen;

        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_a       = 8'h00;
        bus.cmd_b       = 8'h00;
        bus.cmd_use_acc = 1'b0;
        bus.rsp_ready   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_ovf_count", 32'(bus.ovf_count), 32'd0);
        check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("reset_intop1", 32'(bus.intop1), 32'd0);
        check("reset_opcode", 32'(bus.opcode), 32'd0);

        // Accept at edge N -> EXEC after N+1 -> rsp_valid after N+2
        push(2'b00, 8'd20, 8'd30, 1'b0);
        check("lat_n0_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_n1_valid", 32'(bus.rsp_valid), 32'd0);
        check("lat_n1_intop1", 32'(bus.intop1), 32'd20);
        @(negedge clk);
        check("lat_n2_valid", 32'(bus.rsp_valid), 32'd1);
        get_rsp(hs, d);
        check("t1_add_data", 32'(d), 32'h0032);

        push(2'b00, 8'hFF, 8'h01, 1'b0);
        get_rsp(hs, d);
        check("t2_add_wrap", 32'(d), 32'h0000);
        push(2'b11, 8'hFF, 8'hFF, 1'b0);
        get_rsp(hs, d);
        check("t2_mult", 32'(d), 32'hFE01);

        push(2'b00, 8'd5, 8'd3, 1'b0);
        get_rsp(hs, d);
        push(2'b01, 8'hAA, 8'h0C, 1'b1);
        get_rsp(hs, d);
        check("t3_chain", 32'(d), 32'h0008);

        for (int i = 0; i < 30; i++) begin
            push(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
            if (exp_q.size() >= DEPTH + 1 || $urandom_range(0, 1) == 1) get_rsp(hs, d);
        end
        while (exp_q.size() > 0) get_rsp(hs, d);

        // Fill while the consumer stalls
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        check("t4_full_ready", 32'(bus.cmd_ready), 32'd0);
        check("t4_valid", 32'(bus.rsp_valid), 32'd1);
        held = bus.rsp_data;
        repeat (5) @(negedge clk);
        check("t4_hold_data", 32'(bus.rsp_data), 32'(held));
        check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
        prev_hs = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            get_rsp(hs, d);
            if (i > 0) check("t4_spacing", 32'(hs - prev_hs), 32'd2);
            prev_hs = hs;
        end

        // Reset while holding a response with two queued behind it
        force_ovf = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b0);
        end
        for (int t = 0; t < 20 && !bus.rsp_valid; t++) @(negedge clk);
        check("t5_pre_valid", 32'(bus.rsp_valid), 32'd1);
        check("t5_pre_ovf", 32'(bus.ovf_count), 32'(exp_q[0].cnt));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_acc = 8'h00;
        m_cnt = 8'h00;
        force_ovf = 1'b0;
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_ovf_count", 32'(bus.ovf_count), 32'd0);
        check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        bus.rsp_ready = 1'b0;
        check("t5_no_stale", 32'(seen), 32'd0);

        // Saturation of ovf_count
        force_ovf = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(2'b00, 8'($urandom), 8'($urandom), 1'($urandom));
            get_rsp(hs, d);
        end
        force_ovf = 1'b0;
        check("t6_saturate", 32'(bus.ovf_count), 32'h00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
